cla_seq_adder: RTL and testbench

//  Nibble-serial wide adder: accepts two WIDTH-bit operands over a valid/ready

---
 rtl/cla_seq_adder.sv | 155 +++++++++++++++
 tb/tb_cla_seq_adder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: nibble-serial WIDTH-bit adder driving one 4-bit carry-lookahead slice.
// Optional signed-overflow port/logic enabled by defining CLA_SEQ_OVF_EN.

module cla4_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
`ifdef CLA_SEQ_OVF_EN
   output logic       ov,
`endif
   output logic       co
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c[0] = ci;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (&p & c[0]);
      s    = p ^ c[3:0];
      co   = c[4];
   end

`ifdef CLA_SEQ_OVF_EN
   assign ov = c[3] ^ c[4];
`endif
endmodule

module cla_seq_adder #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef CLA_SEQ_OVF_EN
   output logic             ovf,
`endif
   output logic             busy
);
   localparam int unsigned NIB = WIDTH / 4;
   localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIB - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [IW-1:0]    nib_idx;
   logic             carry_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [3:0]       na;
   logic [3:0]       nb;
   logic [3:0]       ns;
   logic             nco;
`ifdef CLA_SEQ_OVF_EN
   logic             nov;
`endif

   assign in_ready = (state == IDLE) & rst_n;

   always_comb begin
      na = '0;
      nb = '0;
      for (int unsigned i = 0; i < NIB; i++) begin
         if (nib_idx == IW'(i)) begin
            na = a_q[4*i +: 4];
            nb = b_q[4*i +: 4];
         end
      end
   end

   cla4_slice u_slice (
      .a  (na),
      .b  (nb),
      .ci (carry_q),
      .s  (ns),
`ifdef CLA_SEQ_OVF_EN
      .ov (nov),
`endif
      .co (nco)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         nib_idx   <= '0;
         carry_q   <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= cin;
                  nib_idx <= '0;
                  sum     <= '0;
                  busy    <= 1'b1;
`ifdef CLA_SEQ_OVF_EN
                  ovf     <= 1'b0;
`endif
                  state   <= RUN;
               end
            end
            RUN: begin
               for (int unsigned i = 0; i < NIB; i++) begin
                  if (nib_idx == IW'(i)) sum[4*i +: 4] <= ns;
               end
               carry_q <= nco;
               if (nib_idx == LAST) begin
                  cout      <= nco;
                  out_valid <= 1'b1;
`ifdef CLA_SEQ_OVF_EN
                  ovf       <= nov;
`endif
                  state     <= DONE;
               end else begin
                  nib_idx <= nib_idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder: 16-bit directed/random ops plus a 4-bit random instance.
// Define CLA_SEQ_OVF_EN to also exercise the ovf port.

module tb_cla_seq_adder;
   localparam int unsigned W  = 16;
   localparam int unsigned W4 = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0, in_ready, cin = 1'b0;
   logic          out_valid, out_ready = 1'b0, cout, busy;
   logic [W-1:0]  a = '0, b = '0, sum;
   logic          in_valid4 = 1'b0, in_ready4, cin4 = 1'b0;
   logic          out_valid4, out_ready4 = 1'b0, cout4, busy4;
   logic [W4-1:0] a4 = '0, b4 = '0, sum4;
`ifdef CLA_SEQ_OVF_EN
   logic          ovf, ovf4;
`endif

   int unsigned   n_cmp = 0, n_bad = 0, n_acc = 0, n_acc4 = 0;
   logic [W:0]    q[$];
   logic [W4:0]   q4[$];

   always #5 clk = ~clk;

   cla_seq_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout),
`ifdef CLA_SEQ_OVF_EN
      .ovf(ovf),
`endif
      .busy(busy)
   );

   cla_seq_adder #(.WIDTH(W4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
      .sum(sum4), .cout(cout4),
`ifdef CLA_SEQ_OVF_EN
      .ovf(ovf4),
`endif
      .busy(busy4)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: push the reference sum on every accepted request, pop on every delivered result.
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready) begin
         q.push_back({1'b0, a} + {1'b0, b} + (W+1)'(cin));
         n_acc++;
      end
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) check("extra_result16", 64'(out_valid), 64'd0);
         else check("result16", {cout, sum}, q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst_n && in_valid4 && in_ready4) begin
         q4.push_back({1'b0, a4} + {1'b0, b4} + (W4+1)'(cin4));
         n_acc4++;
      end
      if (rst_n && out_valid4 && out_ready4) begin
         if (q4.size() == 0) check("extra_result4", 64'(out_valid4), 64'd0);
         else check("result4", {cout4, sum4}, q4.pop_front());
      end
   end

   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
      int unsigned k = 0;
      @(posedge clk); #1;
      a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("accept", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int unsigned cyc);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!out_valid && cyc < 100);
   endtask

   task automatic wait_idle();
      int unsigned k = 0;
      while ((busy || out_valid || q.size() != 0) && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      check("idle", 64'(busy), 64'd0);
   endtask

   task automatic run_random16(input int unsigned nops);
      int unsigned sent = 0, seen = n_acc, cyc = 0;
      while ((sent < nops || q.size() != 0 || busy) && cyc < 30000) begin
         @(posedge clk); #1;
         cyc++;
         out_ready = 1'($urandom_range(0, 1));
         if (in_valid && n_acc != seen) begin
            in_valid = 1'b0;
            seen = n_acc;
            sent++;
         end
         if (!in_valid) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            if (sent < nops && $urandom_range(0, 2) == 0) in_valid = 1'b1;
         end
      end
      check("rand16_drained", 64'(q.size()), 64'd0);
      check("rand16_count", 64'(sent), 64'(nops));
      out_ready = 1'b1;
   endtask

   task automatic run_random4(input int unsigned nops);
      int unsigned sent = 0, seen = n_acc4, cyc = 0;
      while ((sent < nops || q4.size() != 0 || busy4) && cyc < 30000) begin
         @(posedge clk); #1;
         cyc++;
         out_ready4 = 1'($urandom_range(0, 1));
         if (in_valid4 && n_acc4 != seen) begin
            in_valid4 = 1'b0;
            seen = n_acc4;
            sent++;
         end
         if (!in_valid4) begin
            a4 = W4'($urandom); b4 = W4'($urandom); cin4 = 1'($urandom);
            if (sent < nops && $urandom_range(0, 2) == 0) in_valid4 = 1'b1;
         end
      end
      check("rand4_drained", 64'(q4.size()), 64'd0);
      check("rand4_count", 64'(sent), 64'(nops));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
      $fatal(1);
   end

   initial begin
      int unsigned cyc, nbusy;

      #1;
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      #1 check("idle_in_ready", 64'(in_ready), 64'd1);

      // Full carry ripple across every nibble
      send(16'hFFFF, 16'h0001, 1'b0);
      wait_valid(cyc);
      check("latency", 64'(cyc), 64'd4);
      wait_idle();

      send(16'h1234, 16'h4321, 1'b1);
      nbusy = 0;
      while (busy && nbusy < 50) begin
         nbusy++;
         @(posedge clk); #1;
      end
      check("busy_cycles", 64'(nbusy), 64'd5);
      wait_idle();

      // Consumer stall: result must hold and new requests must be refused
      out_ready = 1'b0;
      send(16'h00F0, 16'h0010, 1'b0);
      wait_valid(cyc);
      check("stall_latency", 64'(cyc), 64'd4);
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'(i % 2);
         a = 16'hDEAD; b = 16'hBEEF;
         @(negedge clk);
         check("stall_out_valid", 64'(out_valid), 64'd1);
         check("stall_sum", 64'(sum), 64'h0100);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("release_out_valid", 64'(out_valid), 64'd0);
      check("release_in_ready", 64'(in_ready), 64'd1);
      check("release_sum_held", 64'(sum), 64'h0100);

      // Abort in the second RUN cycle
      send(16'h1234, 16'h4321, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort_sum", 64'(sum), 64'd0);
      check("abort_cout", 64'(cout), 64'd0);
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd0);
      q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 check("abort_restart_ready", 64'(in_ready), 64'd1);
      send(16'h0001, 16'h0001, 1'b0);
      wait_valid(cyc);
      check("post_abort_sum", 64'(sum), 64'h0002);
      wait_idle();

`ifdef CLA_SEQ_OVF_EN
      send(16'h7FFF, 16'h0001, 1'b0);
      wait_valid(cyc);
      check("ovf_pos", 64'(ovf), 64'd1);
      wait_idle();
      send(16'hFFFF, 16'hFFFF, 1'b0);
      check("ovf_clear_on_capture", 64'(ovf), 64'd0);
      wait_valid(cyc);
      check("ovf_neg", 64'(ovf), 64'd0);
      check("ovf_neg_cout", 64'(cout), 64'd1);
      wait_idle();
`endif

      run_random16(300);
      wait_idle();
      run_random4(300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
